// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit adder/subtractor with valid/ready handshakes on both sides.
// Each stage adds one CHUNK-bit slice and registers its carry into the next
// stage. Operand slices that have not been added yet and result slices that
// are already done travel forward with the beat, so no slice is recomputed.
// Latency is STAGES = N/CHUNK cycles, and throughput is one beat per cycle.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready is combinational
//   A, B, sub           operands; sub=0 gives Z=A+B, sub=1 gives Z=A-B
//   out_valid/out_ready result handshake
//   Z                   result, modulo 2^N
//   Cout                carry out of the MSB (for subtract, 1 means no borrow)
//   overflow            signed two's-complement overflow
//   zero                Z == 0
`default_nettype none

module pipelined_add_sub #(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Z,
    output logic         Cout,
    output logic         overflow,
    output logic         zero
);

    localparam int unsigned STAGES = N / CHUNK;

    logic         advance;
    logic [N-1:0] b_eff;
    logic         ovf_q;
    logic         zero_q;

    // The whole pipe moves as one unit. It stalls only when the held output is not accepted.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtract is A + ~B + 1. The +1 enters as the stage-0 carry-in.
    assign b_eff = sub ? ~B : B;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned RW = (k + 1) * CHUNK;

        logic [CHUNK-1:0] a_s;
        logic [CHUNK-1:0] b_s;
        logic             cin;
        logic             vin;
        logic [CHUNK:0]   sum;
        logic [RW-1:0]    res;
        logic             v_q;
        logic             c_q;
        logic [RW-1:0]    r_q;

        // Slice source: stage 0 reads the ports; later stages read the skew of the previous stage.
        if (k == 0) begin : g_src
            assign a_s = A[CHUNK-1:0];
            assign b_s = b_eff[CHUNK-1:0];
            assign cin = sub;
            assign vin = in_valid;
            assign res = sum[CHUNK-1:0];
        end else begin : g_src
            assign a_s = g_stg[k-1].g_sk.a_q[CHUNK-1:0];
            assign b_s = g_stg[k-1].g_sk.b_q[CHUNK-1:0];
            assign cin = g_stg[k-1].c_q;
            assign vin = g_stg[k-1].v_q;
            assign res = {sum[CHUNK-1:0], g_stg[k-1].r_q};
        end

        // One CHUNK+1 wide add. The top bit is the carry into the next slice.
        assign sum = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, cin};

        // Stage register: valid bit, carry out, and the result bits done so far.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (advance) begin
                v_q <= vin;
                c_q <= sum[CHUNK];
                r_q <= res;
            end
        end

        // Skew registers hold the operand slices that later stages still need to add.
        if (k < STAGES - 1) begin : g_sk
            localparam int unsigned SW = N - RW;

            logic [SW-1:0] a_d;
            logic [SW-1:0] b_d;
            logic [SW-1:0] a_q;
            logic [SW-1:0] b_q;

            if (k == 0) begin : g_skd
                assign a_d = A[N-1:CHUNK];
                assign b_d = b_eff[N-1:CHUNK];
            end else begin : g_skd
                assign a_d = g_stg[k-1].g_sk.a_q[SW+CHUNK-1:CHUNK];
                assign b_d = g_stg[k-1].g_sk.b_q[SW+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        // The last stage also registers the flags from its own slice and the full result.
        if (k == STAGES - 1) begin : g_flg
            logic msb_cin;

            // Carry into bit N-1 is recovered from the MSB sum bit and its operand bits.
            assign msb_cin = sum[CHUNK-1] ^ a_s[CHUNK-1] ^ b_s[CHUNK-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= msb_cin ^ sum[CHUNK];
                    zero_q <= (res == '0);
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].v_q;
    assign Z         = g_stg[STAGES-1].r_q;
    assign Cout      = g_stg[STAGES-1].c_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
// Testbench for pipelined_add_sub. It checks the default 32/8 instance with
// directed beats, a backpressured stream and a reset while beats are in
// flight. It also streams random beats through the 32/32, 16/4 and 64/16
// instances. Expected results come from a whole-word arithmetic model and
// are queued when an input beat transfers.
`timescale 1ns/1ps

module tb_pipelined_add_sub;

    typedef struct {
        logic [63:0] z;
        logic        cout;
        logic        ovf;
        logic        zero;
        int unsigned issue;
        logic        lat_chk;
        int          tag;
    } exp_t;

    localparam int unsigned MAIN_LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic        cout;
    logic        ovf;
    logic        zero;

    // Parameter-sweep instances share one operand stream
    logic        sw_valid;
    logic [63:0] sw_a;
    logic [63:0] sw_b;
    logic        sw_sub;
    logic        sw_ordy;
    logic [2:0]  sw_ir;
    logic [2:0]  sw_ov;
    logic [2:0]  sw_co;
    logic [2:0]  sw_of;
    logic [2:0]  sw_ze;
    logic [31:0] z0;
    logic [15:0] z1;
    logic [63:0] z2;

    int unsigned sw_w   [3] = '{32, 16, 64};
    int unsigned sw_lat [3] = '{1, 4, 4};

    exp_t        mq[$];
    exp_t        sq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int          n_out = 0;
    int          sw_out = 0;
    logic        lat_on;
    logic        last_in_fire;
    logic        last_in_ready;

    pipelined_add_sub #(.N(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .Z(z), .Cout(cout), .overflow(ovf), .zero(zero)
    );

    pipelined_add_sub #(.N(32), .CHUNK(32)) u_sw0 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[0]),
        .A(sw_a[31:0]), .B(sw_b[31:0]), .sub(sw_sub), .out_valid(sw_ov[0]), .out_ready(sw_ordy),
        .Z(z0), .Cout(sw_co[0]), .overflow(sw_of[0]), .zero(sw_ze[0])
    );

    pipelined_add_sub #(.N(16), .CHUNK(4)) u_sw1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[1]),
        .A(sw_a[15:0]), .B(sw_b[15:0]), .sub(sw_sub), .out_valid(sw_ov[1]), .out_ready(sw_ordy),
        .Z(z1), .Cout(sw_co[1]), .overflow(sw_of[1]), .zero(sw_ze[1])
    );

    pipelined_add_sub #(.N(64), .CHUNK(16)) u_sw2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[2]),
        .A(sw_a), .B(sw_b), .sub(sw_sub), .out_valid(sw_ov[2]), .out_ready(sw_ordy),
        .Z(z2), .Cout(sw_co[2]), .overflow(sw_of[2]), .zero(sw_ze[2])
    );

    // Whole-word reference: n-bit add or subtract with carry, overflow and zero
    function automatic exp_t model(input logic [63:0] ia, input logic [63:0] ib,
                                   input logic is, input int n);
        exp_t        r;
        logic [64:0] m;
        logic [64:0] hm;
        logic [64:0] am;
        logic [64:0] bm;
        logic [64:0] full;
        logic [64:0] low;
        m    = (n == 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << n) - 65'd1);
        hm   = m >> 1;
        am   = {1'b0, ia} & m;
        bm   = {1'b0, (is ? ~ib : ib)} & m;
        full = am + bm + 65'(is);
        low  = (am & hm) + (bm & hm) + 65'(is);
        r.z       = 64'(full & m);
        r.cout    = full[n];
        r.ovf     = low[n-1] ^ full[n];
        r.zero    = ((full & m) == 65'd0);
        r.issue   = 0;
        r.lat_chk = 1'b0;
        r.tag     = 0;
        return r;
    endfunction

    function automatic logic [63:0] sw_z(input int i);
        case (i)
            0:       return {32'd0, z0};
            1:       return {48'd0, z1};
            default: return z2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes 1ns before the rising edge, then move to the next falling edge
    task automatic tick();
        exp_t e;
        int   idx;
        #4;
        last_in_ready = in_ready;
        last_in_fire  = 1'b0;
        if (!rst) begin
            if (out_valid && mq.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                e = mq[0];
                chk("z", {32'd0, z}, e.z);
                chk("cout", 64'(cout), 64'(e.cout));
                chk("overflow", 64'(ovf), 64'(e.ovf));
                chk("zero", 64'(zero), 64'(e.zero));
                if (out_ready) begin
                    if (e.lat_chk) chk("latency", 64'(cyc - e.issue), 64'(MAIN_LAT));
                    void'(mq.pop_front());
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                e = model({32'd0, a}, {32'd0, b}, sub, 32);
                e.issue   = cyc;
                e.lat_chk = lat_on;
                mq.push_back(e);
                last_in_fire = 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                if (sw_ov[i]) begin
                    idx = -1;
                    foreach (sq[j]) if (idx < 0 && sq[j].tag == i) idx = j;
                    if (idx < 0) begin
                        chk($sformatf("sw%0d_spurious", i), 64'(sw_ov[i]), 64'd0);
                    end else begin
                        e = sq[idx];
                        chk($sformatf("sw%0d_z", i), sw_z(i), e.z);
                        chk($sformatf("sw%0d_flags", i), {61'd0, sw_co[i], sw_of[i], sw_ze[i]},
                            {61'd0, e.cout, e.ovf, e.zero});
                        chk($sformatf("sw%0d_latency", i), 64'(cyc - e.issue), 64'(sw_lat[i]));
                        sq.delete(idx);
                        sw_out++;
                    end
                end
                if (sw_valid && sw_ir[i]) begin
                    e = model(sw_a, sw_b, sw_sub, int'(sw_w[i]));
                    e.issue = cyc;
                    e.tag   = i;
                    sq.push_back(e);
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            sq.delete();
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic is);
        a        = ia;
        b        = ib;
        sub      = is;
        in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (last_in_fire) break;
        end
        chk("send_accepted", 64'(last_in_fire), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget && (mq.size() != 0 || sq.size() != 0); t++) tick();
        chk("drain_main_empty", 64'(mq.size()), 64'd0);
        chk("drain_sweep_empty", 64'(sq.size()), 64'd0);
    endtask

    initial begin
        int n0;
        int k;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_ordy = 1'b1;
        lat_on = 1'b1; last_in_fire = 1'b0; last_in_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_z", {32'd0, z}, 64'd0);
        chk("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed single beats with latency checks
        send(32'h0000_00FF, 32'h0000_0001, 1'b0); drain(20);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); drain(20);
        send(32'd5,         32'd7,         1'b1); drain(20);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); drain(20);
        send(32'h8000_0000, 32'h0000_0001, 1'b1); drain(20);

        // Back-to-back stream with out_ready low on cycles 6-8
        lat_on = 1'b0;
        n0 = n_out;
        k = 0;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        for (int c = 0; c < 40 && k < 10; c++) begin
            out_ready = !(c >= 6 && c <= 8);
            in_valid  = 1'b1;
            tick();
            if (c == 7) chk("stall_in_ready", 64'(last_in_ready), 64'd0);
            if (last_in_fire) begin
                k++;
                a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(30);
        chk("b2b_count", 64'(n_out - n0), 64'd10);

        // Reset at cycle 2 with beats in flight; none may be emitted
        lat_on = 1'b1;
        n0 = n_out;
        in_valid = 1'b1;
        a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; tick();
        a = 32'h3333_3333; b = 32'h0000_0001; sub = 1'b1; tick();
        rst = 1'b1;
        a = 32'h5555_5555; b = 32'h0000_0005; sub = 1'b0; tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_z", {32'd0, z}, 64'd0);
        for (int t = 0; t < 8; t++) tick();
        chk("midrst_none_emitted", 64'(n_out - n0), 64'd0);
        send(32'hDEAD_BEEF, 32'h1234_5678, 1'b1); drain(20);

        // Random stream through the swept parameter sets, including boundary operands
        sw_valid = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (j == 0) begin
                sw_a = '1; sw_b = 64'd1; sw_sub = 1'b0;
            end else if (j == 1) begin
                sw_a = '0; sw_b = '0; sw_sub = 1'b1;
            end else begin
                sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
                sw_sub = 1'($urandom_range(0, 1));
            end
            tick();
        end
        sw_valid = 1'b0;
        drain(20);
        chk("sweep_count", 64'(sw_out), 64'd60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined N-bit adder/subtractor with valid/ready handshakes on both sides.
- The operand width is split into CHUNK-bit slices. Each pipeline stage adds one slice and registers its carry into the next stage.
- Produces sum/difference, carry-out, signed overflow and zero flags.
- Sits between the register-file read stage and the ALU result mux. It is the multi-cycle, high-fmax replacement for the single-cycle ripple adder.

Parameters:
- N, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage. STAGES = N/CHUNK (default 4); N = CHUNK is legal and gives 1 stage.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- A  input  N  operand A
- B  input  N  operand B
- sub  input  1  0: Z=A+B; 1: Z=A-B
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result this cycle
- Z  output  N  result
- Cout  output  1  carry out of MSB (for sub: 1 means no borrow)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  Z == 0

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stall rule: advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance=0, every stage register, including valid bits, holds its value.
  - A held output beat keeps Z/Cout/overflow/zero stable until accepted.
- Subtraction: stage 0 uses B' = ~B and carry-in = sub. Addition uses B' = B, carry-in 0.
- Stage k (0..STAGES-1):
  - Adds slice k of A and B' plus the carry from stage k-1 (stage 0 uses carry-in).
  - Registers the slice result, the carry, and a valid bit.
- Operand skew: upper slices not yet consumed travel with the beat in skew registers. Already-computed lower result slices travel forward with it as well. No slice is recomputed.
- Latency: result appears on out_valid exactly STAGES cycles after the input transfer, absent stalls. Throughput is 1 beat/cycle with out_ready held high.
- Flags, computed in the last stage from final-stage data:
  - Cout = carry out of bit N-1.
  - overflow = carry into bit N-1 XOR carry out of bit N-1.
  - zero = (Z == 0).
- Bubbles: a stage with valid=0 may hold any data. Only valid bits must be correct.
- Reset, sampled at a clk edge while rst=1:
  - All stage valid bits clear, so out_valid=0; in_ready=1 after reset.
  - Z, Cout, overflow and zero reset to 0.
  - Beats in flight when rst asserts are discarded, never emitted.
  - An input presented in the same cycle as rst=1 is dropped.
- Simultaneous events:
  - Output accepted and new input in the same cycle: both transfer, no bubble inserted.
  - Stall with in_valid=1: in_ready=0, the input is not captured, and the source must hold it.
- Wrap-around: A+B wraps modulo 2^N; Cout reports the lost bit.
- Width rules: all internal slice adds are CHUNK+1 bits wide. No sign extension.

Test Plan (N=32, CHUNK=8, latency 4):
- Basic add:
  - Stimulus: A=0x0000_00FF, B=0x0000_0001, sub=0, single beat.
  - Required: out_valid on cycle 4 with Z=0x0000_0100, Cout=0, overflow=0, zero=0. Exercises carry across slice 0→1.
- Full carry chain:
  - Stimulus: A=0xFFFF_FFFF, B=0x0000_0001.
  - Required: Z=0x0000_0000, Cout=1, zero=1, overflow=0.
- Subtract and overflow:
  - Stimulus: A=5, B=7, sub=1.
  - Required: Z=0xFFFF_FFFE, Cout=0, overflow=0.
  - Stimulus: A=0x7FFF_FFFF, B=0x0000_0001, add.
  - Required: Z=0x8000_0000, overflow=1.
  - Stimulus: A=0x8000_0000, B=1, sub=1.
  - Required: Z=0x7FFF_FFFF, overflow=1, Cout=1.
- Back-to-back with backpressure:
  - Stimulus: stream 10 random beats with in_valid=1 continuously; hold out_ready=0 for cycles 6-8.
  - Required: in_ready falls while stalled, no beat is lost or duplicated, results match the golden model in order, and the held Z stays stable.
- Reset mid-flight:
  - Stimulus: inject 3 beats, assert rst for 1 cycle at cycle 2.
  - Required: out_valid=0 and Z=0 after reset, none of the 3 results is ever emitted, and the next beat after reset completes with 4-cycle latency.
- Parameter sweep:
  - Stimulus: rerun the random golden-model test at (N,CHUNK) = (32,32), (16,4), (64,16).
  - Required: latency equals N/CHUNK and all results match.
